// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between two byte requesters, the arbiter and one uart_m
// transmitter. The arbiter sits on the slave side; requesters and the
// transmitter (or a bench standing in for them) sit on the master side.
interface uart_tx_arb_if;
    logic       r0_valid;
    logic [7:0] r0_data;
    logic       r0_last;
    logic       r0_ready;
    logic       r1_valid;
    logic [7:0] r1_data;
    logic       r1_last;
    logic       r1_ready;
    logic       load;
    logic [7:0] d;
    logic       txbusy;
    logic [1:0] grant;
    logic       locked;
    logic       err;

    modport slave (
        input  r0_valid, r0_data, r0_last,
        input  r1_valid, r1_data, r1_last,
        input  txbusy,
        output r0_ready, r1_ready,
        output load, d, grant, locked, err
    );

    modport master (
        output r0_valid, r0_data, r0_last,
        output r1_valid, r1_data, r1_last,
        output txbusy,
        input  r0_ready, r1_ready,
        input  load, d, grant, locked, err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_m transmitter between two byte
// requesters. One byte is in flight at a time: accept, pulse load, wait for
// txbusy to rise (with a timeout), then wait for it to fall. With LOCKPKT set,
// a requester keeps the transmitter until it hands over a byte marked last.
module uart_tx_arb #(
    parameter bit         LOCKPKT    = 1'b1,
    parameter logic [3:0] ACKTIMEOUT = 4'd15
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_arb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACKWAIT,
        S_BUSY
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] d_q, d_d;
    logic [1:0] grant_q, grant_d;
    logic       locked_q, locked_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_owner_q, last_owner_d;

    logic       ready0;
    logic       ready1;
    logic       load;
    logic       err;

    // Pick which requester may hand over a byte this cycle (IDLE, transmitter free).
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst && state_q == S_IDLE && !bus.txbusy) begin
            if (locked_q) begin
                // The lock owner is always the last requester served.
                if (last_owner_q) ready1 = bus.r1_valid;
                else              ready0 = bus.r0_valid;
            end else if (bus.r0_valid && bus.r1_valid) begin
                // Tie: the requester that was not served last wins.
                if (last_owner_q) ready0 = 1'b1;
                else              ready1 = 1'b1;
            end else begin
                ready0 = bus.r0_valid;
                ready1 = bus.r1_valid;
            end
        end
    end

    // Sequence one byte through accept, load, ack wait and busy.
    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        grant_d      = grant_q;
        locked_d     = locked_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        load         = 1'b0;
        err          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready0 || ready1) begin
                    d_d          = ready1 ? bus.r1_data : bus.r0_data;
                    grant_d      = ready1 ? 2'b10 : 2'b01;
                    last_owner_d = ready1;
                    if (LOCKPKT) begin
                        locked_d = ready1 ? !bus.r1_last : !bus.r0_last;
                    end
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                load    = 1'b1;
                cnt_d   = 4'd0;
                state_d = S_ACKWAIT;
            end

            S_ACKWAIT: begin
                if (bus.txbusy) begin
                    state_d = S_BUSY;
                end else if (cnt_q == ACKTIMEOUT) begin
                    // Transmitter never acknowledged: drop the byte and any lock.
                    err      = 1'b1;
                    locked_d = 1'b0;
                    grant_d  = 2'b00;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_BUSY: begin
                if (!bus.txbusy) begin
                    if (!locked_q) grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            d_q          <= 8'h00;
            grant_q      <= 2'b00;
            locked_q     <= 1'b0;
            cnt_q        <= 4'd0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            grant_q      <= grant_d;
            locked_q     <= locked_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.r0_ready = ready0;
    assign bus.r1_ready = ready1;
    assign bus.load     = load;
    assign bus.d        = d_q;
    assign bus.grant    = grant_q;
    assign bus.locked   = locked_q;
    assign bus.err      = err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two instances (packet lock on / 15-cycle ack timeout,
// and packet lock off / 4-cycle ack timeout) see identical requester traffic.
// Each has its own transmitter stand-in. The accepted byte order is compared
// against a transaction-level round-robin/lock model run over the queued bytes.
module tb_uart_tx_arb;

    localparam bit         LOCK_A = 1'b1;
    localparam bit         LOCK_B = 1'b0;
    localparam logic [3:0] TO_A   = 4'd15;
    localparam logic [3:0] TO_B   = 4'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if ifa ();
    uart_tx_arb_if ifb ();

    uart_tx_arb #(.LOCKPKT(LOCK_A), .ACKTIMEOUT(TO_A)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    uart_tx_arb #(.LOCKPKT(LOCK_B), .ACKTIMEOUT(TO_B)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct packed {
        logic       v0, l0;
        logic [7:0] d0;
        logic       v1, l1;
        logic [7:0] d1;
        logic       rd0, rd1, load;
        logic [7:0] d;
        logic       busy;
        logic [1:0] grant;
        logic       locked, err;
    } mon_t;

    // Requester byte queues {last, data}, per DUT and requester.
    logic [8:0] rq   [2][2][$];
    // Accepted / predicted transfers {req, last, data}.
    logic [9:0] acc_log [2][$];
    logic [9:0] pred    [2][$];

    bit         lockpkt [2];
    int         tmo [2];
    bit         mute [2];
    int         busy_left [2];
    bit         pend [2];
    bit         pop_req [2][2];
    bit         in_frame [2];
    bit         prev_busy [2];
    bit         fell_chk [2];
    bit         err_chk [2];
    int         last_acc_cyc [2];
    int         last_load_cyc [2];
    logic [9:0] last_acc [2];
    int         load_cnt [2];
    int         err_cnt [2];
    bit         m_last_owner [2];
    bit         m_lock [2];
    int         fmin, fmax;
    int         cyc;
    int         n_assert;
    int         n_fail;

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%s %s: observed %0h expected %0h", (k == 0) ? "A" : "B", tag, obs, exp);
        end
    endtask

    function automatic mon_t get_mon(input int k);
        mon_t m;
        if (k == 0) begin
            m.v0 = ifa.r0_valid; m.l0 = ifa.r0_last; m.d0 = ifa.r0_data;
            m.v1 = ifa.r1_valid; m.l1 = ifa.r1_last; m.d1 = ifa.r1_data;
            m.rd0 = ifa.r0_ready; m.rd1 = ifa.r1_ready; m.load = ifa.load; m.d = ifa.d;
            m.busy = ifa.txbusy; m.grant = ifa.grant; m.locked = ifa.locked; m.err = ifa.err;
        end else begin
            m.v0 = ifb.r0_valid; m.l0 = ifb.r0_last; m.d0 = ifb.r0_data;
            m.v1 = ifb.r1_valid; m.l1 = ifb.r1_last; m.d1 = ifb.r1_data;
            m.rd0 = ifb.r0_ready; m.rd1 = ifb.r1_ready; m.load = ifb.load; m.d = ifb.d;
            m.busy = ifb.txbusy; m.grant = ifb.grant; m.locked = ifb.locked; m.err = ifb.err;
        end
        return m;
    endfunction

    task automatic set_if(input int k, input logic [8:0] f0, input logic v0,
                          input logic [8:0] f1, input logic v1, input logic b);
        if (k == 0) begin
            ifa.r0_valid = v0; ifa.r0_last = f0[8]; ifa.r0_data = f0[7:0];
            ifa.r1_valid = v1; ifa.r1_last = f1[8]; ifa.r1_data = f1[7:0];
            ifa.txbusy   = b;
        end else begin
            ifb.r0_valid = v0; ifb.r0_last = f0[8]; ifb.r0_data = f0[7:0];
            ifb.r1_valid = v1; ifb.r1_last = f1[8]; ifb.r1_data = f1[7:0];
            ifb.txbusy   = b;
        end
    endtask

    // Per-cycle observation of one DUT, sampled at the falling edge.
    task automatic observe(input int k, input mon_t m);
        logic [9:0] e;
        if (err_chk[k]) begin
            chk(k, "grant after err", 32'(m.grant), 32'(2'b00));
            chk(k, "locked after err", 32'(m.locked), 32'(1'b0));
            chk(k, "err width", 32'(m.err), 32'(1'b0));
            err_chk[k] = 1'b0;
        end
        if (fell_chk[k]) begin
            chk(k, "grant after txbusy falls", 32'(m.grant),
                (lockpkt[k] && !last_acc[k][8]) ? 32'({last_acc[k][9], !last_acc[k][9]}) : 32'(2'b00));
            fell_chk[k] = 1'b0;
        end
        if (prev_busy[k] && !m.busy && in_frame[k]) begin
            fell_chk[k] = 1'b1;
            in_frame[k] = 1'b0;
        end
        prev_busy[k] = m.busy;

        if (m.rd0 || m.rd1) begin
            chk(k, "readys exclusive", 32'(m.rd0 & m.rd1), 32'(1'b0));
            chk(k, "ready while txbusy", 32'(m.busy), 32'(1'b0));
            chk(k, "ready without valid", 32'(m.rd1 ? m.v1 : m.v0), 32'(1'b1));
            e = m.rd1 ? {1'b1, m.l1, m.d1} : {1'b0, m.l0, m.d0};
            acc_log[k].push_back(e);
            last_acc[k]     = e;
            last_acc_cyc[k] = cyc;
            pop_req[k][m.rd1 ? 1 : 0] = 1'b1;
        end
        if (m.load) begin
            chk(k, "load latency", cyc - last_acc_cyc[k], 1);
            chk(k, "d at load", 32'(m.d), 32'(last_acc[k][7:0]));
            chk(k, "grant at load", 32'(m.grant), 32'({last_acc[k][9], !last_acc[k][9]}));
            chk(k, "locked at load", 32'(m.locked), 32'(lockpkt[k] && !last_acc[k][8]));
            pend[k]          = 1'b1;
            in_frame[k]      = 1'b1;
            last_load_cyc[k] = cyc;
            load_cnt[k]++;
        end
        if (m.err) begin
            chk(k, "err delay after load", cyc - last_load_cyc[k], tmo[k] + 1);
            err_chk[k] = 1'b1;
            err_cnt[k]++;
        end
    endtask

    // Requester queues and transmitter stand-in, updated just after the rising edge.
    task automatic drive();
        logic [8:0] f0, f1;
        logic       b;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (pop_req[k][r]) begin
                    void'(rq[k][r].pop_front());
                    pop_req[k][r] = 1'b0;
                end
            end
            if (pend[k]) begin
                pend[k] = 1'b0;
                if (!mute[k]) busy_left[k] = int'($urandom_range(fmax, fmin));
            end
            b = busy_left[k] > 0;
            if (b) busy_left[k]--;
            f0 = (rq[k][0].size() > 0) ? rq[k][0][0] : 9'h000;
            f1 = (rq[k][1].size() > 0) ? rq[k][1][0] : 9'h000;
            set_if(k, f0, rq[k][0].size() > 0, f1, rq[k][1].size() > 0, b);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) observe(k, get_mon(k));
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push(input int r, input logic [8:0] e);
        for (int k = 0; k < 2; k++) rq[k][r].push_back(e);
    endtask

    // Transaction-level order: round robin over non-empty queues, a locked
    // owner keeps the transmitter until it sends a byte marked last.
    task automatic predict();
        logic [8:0] q0[$], q1[$], e;
        bit         n;
        for (int k = 0; k < 2; k++) begin
            q0 = rq[k][0];
            q1 = rq[k][1];
            while (q0.size() + q1.size() > 0) begin
                if (m_lock[k])                          n = m_last_owner[k];
                else if (q0.size() > 0 && q1.size() > 0) n = !m_last_owner[k];
                else                                    n = (q0.size() == 0);
                if (n && q1.size() == 0) break;
                if (!n && q0.size() == 0) break;
                e = n ? q1.pop_front() : q0.pop_front();
                pred[k].push_back({n, e});
                m_last_owner[k] = n;
                m_lock[k]       = lockpkt[k] && !e[8];
            end
        end
    endtask

    task automatic reset_pulse();
        mon_t m;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            m = get_mon(k);
            chk(k, "reset load", 32'(m.load), 32'(1'b0));
            chk(k, "reset d", 32'(m.d), 32'(8'h00));
            chk(k, "reset grant", 32'(m.grant), 32'(2'b00));
            chk(k, "reset locked", 32'(m.locked), 32'(1'b0));
            chk(k, "reset err", 32'(m.err), 32'(1'b0));
            chk(k, "reset r0_ready", 32'(m.rd0), 32'(1'b0));
            chk(k, "reset r1_ready", 32'(m.rd1), 32'(1'b0));
            m_last_owner[k] = 1'b1;
            m_lock[k]       = 1'b0;
            last_acc[k]     = 10'h100;
            in_frame[k]     = 1'b0;
            fell_chk[k]     = 1'b0;
            err_chk[k]      = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int idle;
        int n;
        idle = 0;
        n    = 0;
        while (n < 3000 && idle < 24) begin
            tick();
            n++;
            if (rq[0][0].size() + rq[0][1].size() + rq[1][0].size() + rq[1][1].size() == 0
                && !ifa.txbusy && !ifb.txbusy)
                idle++;
            else
                idle = 0;
        end
        for (int k = 0; k < 2; k++) chk(k, {tag, " drain within budget"}, 32'(n < 3000), 32'(1'b1));
    endtask

    task automatic compare(input string tag, input int exp_err);
        for (int k = 0; k < 2; k++) begin
            chk(k, {tag, " accept count"}, acc_log[k].size(), pred[k].size());
            for (int i = 0; i < acc_log[k].size() && i < pred[k].size(); i++)
                chk(k, $sformatf("%s accept #%0d", tag, i), 32'(acc_log[k][i]), 32'(pred[k][i]));
            chk(k, {tag, " load count"}, load_cnt[k], pred[k].size());
            chk(k, {tag, " err count"}, err_cnt[k], exp_err);
            acc_log[k].delete();
            pred[k].delete();
            load_cnt[k] = 0;
            err_cnt[k]  = 0;
        end
    endtask

    initial begin
        int n0, n1, guard;
        lockpkt[0] = LOCK_A;   lockpkt[1] = LOCK_B;
        tmo[0]     = int'(TO_A); tmo[1]   = int'(TO_B);
        fmin = 4; fmax = 4;
        cyc = 0; n_assert = 0; n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            mute[k] = 1'b0; busy_left[k] = 0; pend[k] = 1'b0; prev_busy[k] = 1'b0;
            pop_req[k][0] = 1'b0; pop_req[k][1] = 1'b0;
            last_acc_cyc[k] = -10; last_load_cyc[k] = -10;
            load_cnt[k] = 0; err_cnt[k] = 0;
            set_if(k, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        end
        reset_pulse();

        // Single byte from r0.
        push(0, 9'h141);
        predict();
        drain("single");
        compare("single", 0);

        // Both requesters continuously valid, made visible under reset.
        for (int i = 0; i < 3; i++) push(0, 9'h141);
        for (int i = 0; i < 2; i++) push(1, 9'h14E);
        tick();
        reset_pulse();
        predict();
        drain("round robin");
        compare("round robin", 0);

        // Three-byte packet from r1 while r0 waits.
        push(1, 9'h001); push(1, 9'h002); push(1, 9'h103);
        push(0, 9'h1A0); push(0, 9'h1A1);
        predict();
        drain("packet");
        compare("packet", 0);

        // Transmitter never acknowledges: both bytes time out.
        mute[0] = 1'b1; mute[1] = 1'b1;
        push(0, 9'h055); push(0, 9'h166);
        predict();
        drain("timeout");
        compare("timeout", 2);
        mute[0] = 1'b0; mute[1] = 1'b0;

        // Random packets and frame lengths.
        fmin = 1; fmax = 6;
        for (int it = 0; it < 4; it++) begin
            n0 = int'($urandom_range(6, 1));
            n1 = int'($urandom_range(6, 1));
            for (int i = 0; i < n0; i++)
                push(0, {(i == n0 - 1) || ($urandom_range(2, 0) == 0), 8'($urandom_range(255, 0))});
            for (int i = 0; i < n1; i++)
                push(1, {(i == n1 - 1) || ($urandom_range(2, 0) == 0), 8'($urandom_range(255, 0))});
            predict();
            drain($sformatf("random%0d", it));
            compare($sformatf("random%0d", it), 0);
        end

        // Reset while a long frame is still on the line.
        fmin = 10; fmax = 10;
        push(1, 9'h177);
        predict();
        guard = 0;
        while ((load_cnt[0] == 0 || load_cnt[1] == 0) && guard < 50) begin
            tick();
            guard++;
        end
        for (int k = 0; k < 2; k++) chk(k, "mid-frame load seen", 32'(guard < 50), 32'(1'b1));
        repeat (3) tick();
        compare("pre-reset", 0);
        push(0, 9'h15A);
        push(1, 9'h133);
        tick();
        reset_pulse();
        predict();
        drain("after reset");
        compare("after reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Two-requester transmit scheduler that shares one uart_m transmitter.
- Accepts bytes from two independent valid/ready sources and drives the uart_m load/d inputs.
- Tracks txbusy to sequence one byte at a time.
- Requester selection is round-robin. A requester can optionally hold the transmitter across a multi-byte packet using a last flag.

Parameters:
- LOCKPKT, 1'b1: 1 = honour rN_last and lock the transmitter to one requester until a byte with last=1 is accepted; 0 = ignore rN_last and arbitrate per byte.
- ACKTIMEOUT, 4'd15: maximum number of cycles after load to wait for txbusy to rise before aborting with err.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous reset, active-high.
- r0_valid, input, 1: requester 0 has a byte.
- r0_data, input, 8: requester 0 byte.
- r0_last, input, 1: requester 0 byte ends its packet.
- r0_ready, output, 1: requester 0 byte accepted this cycle (valid&&ready = transfer).
- r1_valid, input, 1: requester 1 has a byte.
- r1_data, input, 8: requester 1 byte.
- r1_last, input, 1: requester 1 byte ends its packet.
- r1_ready, output, 1: requester 1 byte accepted this cycle.
- load, output, 1: one-cycle pulse to uart_m.load.
- d, output, 8: byte to uart_m.d; stable from the load pulse until the next accept.
- txbusy, input, 1: from uart_m.txbusy.
- grant, output, 2: one-hot current owner; 00 = none.
- locked, output, 1: packet lock active.
- err, output, 1: one-cycle pulse on ack timeout.

Behaviour:
- State machine: IDLE, LOAD, ACKWAIT, BUSY.
- Reset (async, any state): state=IDLE, load=0, d=8'h00, grant=00, locked=0, err=0, ack counter=0, last_owner=1 (so r0 wins the first tie). r0_ready and r1_ready are forced 0 while rst is high.
- IDLE:
  - Eligible only when txbusy==0; while txbusy==1 (e.g. after reset mid-frame) both readys stay 0.
  - If locked: only the locked owner's rN_ready = rN_valid; the other requester's ready = 0.
  - If not locked: a single valid requester gets ready; if both are valid, the requester != last_owner gets ready.
  - rN_ready is combinational from state, valid, lock and last_owner. It may be high only in IDLE; at most one is high.
- On accept (cycle N): d<=rN_data; grant<=onehot(N); last_owner<=N; go to LOAD.
- Lock update on accept (LOCKPKT=1 only): rN_last==0 sets locked=1 (owner N); rN_last==1 clears locked. With LOCKPKT=0, locked stays 0.
- LOAD (cycle N+1): load=1 for exactly this cycle; ack counter cleared; next state ACKWAIT.
- ACKWAIT:
  - txbusy==1 -> BUSY.
  - Otherwise counter increments; when counter==ACKTIMEOUT: err=1 for one cycle, locked<=0, grant<=00, go to IDLE.
- BUSY: txbusy==0 -> IDLE. grant<=00 unless locked, in which case grant holds the owner.
- Earliest next accept is the first IDLE cycle with txbusy==0, giving no idle gap beyond the state transition.
- rN_valid deasserting in any non-IDLE state has no effect; the accepted byte is already in d.
- While locked, if the owner drops valid, the arbiter waits in IDLE indefinitely. The other requester starves by design until last=1.
- Counter width is 4 bits; ACKTIMEOUT=0 gives err on the first ACKWAIT cycle unless txbusy is already 1.

Test Plan:
- Single byte: r0_valid=1, r0_data=8'h41, r0_last=1, uart_m looped back -> r0_ready 1 cycle, load 1 cycle later, d=8'h41, grant=01; receiver gets 8'h41; grant returns 00 after txbusy falls.
- Round-robin: r0 and r1 both continuously valid (8'h41 / 8'h4E, last=1) -> accepted order r0,r1,r0,r1; no two consecutive grants to the same requester; readys never high together.
- Packet lock: r1 sends 3 bytes (8'h01, 8'h02, 8'h03 with last=0,0,1) while r0 is valid -> locked=1 from the first accept; r0_ready stays 0 until 8'h03 is accepted; r0 is served next.
- LOCKPKT=0 with the same stimulus -> bytes interleave r1,r0,r1,r0...; locked stays 0.
- Ack timeout: txbusy tied 0, ACKTIMEOUT=4 -> err pulses exactly 5 cycles after load; state returns to IDLE; locked cleared; next byte accepted.
- Reset mid-frame: assert rst during BUSY with txbusy still high -> outputs at reset values immediately; no ready until txbusy falls; then the pending r0 byte is accepted first.
